// File: rtl/motor_pwm_pkg.sv
// Shared types and constants for the per-motor PWM controller.
package motor_pwm_pkg;

    localparam int unsigned PWM_BITS = 5;
    localparam logic [PWM_BITS-1:0] PWM_MAX = 5'd31;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StReverse,
        StBrake,
        StFault
    } state_e;

    // One duty step toward a target, never past it.
    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        if (cur < tgt) begin
            return cur + 1'b1;
        end else if (cur > tgt) begin
            return cur - 1'b1;
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/pwm_period_gen.sv
// PWM timebase: prescaler of CLK_DIV clocks, 5-bit wrapping counter and period_end strobe.
module pwm_period_gen
    import motor_pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic [PWM_BITS-1:0] counter,
    output logic                period_end
);

    localparam logic [7:0] PrescLast = 8'(CLK_DIV - 1);

    logic [7:0]          presc_q, presc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                tick;

    always_comb begin
        tick    = (presc_q == PrescLast);
        presc_d = tick ? 8'd0 : presc_q + 8'd1;
        cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign counter    = cnt_q;
    assign period_end = tick && (cnt_q == PWM_MAX);

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Brushed-motor H-bridge PWM controller with brake, safe reversal and fault latch-off.
// Duty ramping is built when MOTOR_PWM_CTRL_RAMP_EN is defined; otherwise duty loads directly.
module motor_pwm_ctrl
    import motor_pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 8,
    parameter int unsigned RAMP_PERIODS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] pwm_target,
    input  logic       enable_req,
    input  logic       brake_req,
    input  logic       direction_req,
    input  logic       fault_in,
    input  logic       fault_clear,
    output logic       pwm_out,
    output logic       enable_out,
    output logic       brake_out,
    output logic       direction_out,
    output logic [4:0] duty_applied,
    output logic       fault_latched,
    output logic       busy
);

    if (CLK_DIV == 0 || CLK_DIV > 255 || RAMP_PERIODS == 0 || RAMP_PERIODS > 255) begin : g_bad_cfg
        $error("motor_pwm_ctrl: CLK_DIV and RAMP_PERIODS must lie in 1..255");
    end

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;
    logic                pwm_q, pwm_d;
    logic                fault_meta_q, fault_sync_q;
    logic [PWM_BITS-1:0] counter;
    logic                period_end;
    logic                dir_mismatch;

`ifdef MOTOR_PWM_CTRL_RAMP_EN
    localparam logic [7:0] RampLast = 8'(RAMP_PERIODS - 1);
    logic [7:0] ramp_q, ramp_d;
`else
    logic dead_q, dead_d;
`endif

    pwm_period_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_period_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .counter   (counter),
        .period_end(period_end)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_meta_q <= 1'b0;
            fault_sync_q <= 1'b0;
        end else begin
            fault_meta_q <= fault_in;
            fault_sync_q <= fault_meta_q;
        end
    end

    assign dir_mismatch = (direction_req != dir_q);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
`ifdef MOTOR_PWM_CTRL_RAMP_EN
        ramp_d  = ramp_q;
`else
        dead_d  = dead_q;
`endif
        if (fault_sync_q) begin
            state_d = StFault;
            duty_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    duty_d = '0;
                    if (enable_req) begin
                        state_d = StRun;
`ifdef MOTOR_PWM_CTRL_RAMP_EN
                        ramp_d  = '0;
`endif
                    end
                end
                StFault: begin
                    if (fault_clear) begin
                        state_d = StIdle;
                    end
                end
                StRun, StReverse, StBrake: begin
                    if (!enable_req) begin
                        state_d = StIdle;
                        duty_d  = '0;
                    end else if (brake_req) begin
                        state_d = StBrake;
                        duty_d  = '0;
                    end else if (state_q == StBrake) begin
                        state_d = StRun;
`ifdef MOTOR_PWM_CTRL_RAMP_EN
                        ramp_d  = '0;
`endif
                    end else if (state_q == StRun) begin
`ifdef MOTOR_PWM_CTRL_RAMP_EN
                        if (dir_mismatch) begin
                            state_d = StReverse;
                        end else if (period_end) begin
                            if (ramp_q == RampLast) begin
                                ramp_d = '0;
                                duty_d = step_toward(duty_q, pwm_target);
                            end else begin
                                ramp_d = ramp_q + 8'd1;
                            end
                        end
`else
                        if (dir_mismatch) begin
                            state_d = StReverse;
                            duty_d  = '0;
                            dead_d  = 1'b0;
                        end else if (period_end) begin
                            duty_d = pwm_target;
                        end
`endif
                    end else begin
`ifdef MOTOR_PWM_CTRL_RAMP_EN
                        if (!dir_mismatch) begin
                            state_d = StRun;
                        end else if (period_end) begin
                            if (duty_q == '0) begin
                                dir_d   = ~dir_q;
                                state_d = StRun;
                                ramp_d  = '0;
                            end else if (ramp_q == RampLast) begin
                                ramp_d = '0;
                                duty_d = duty_q - 1'b1;
                            end else begin
                                ramp_d = ramp_q + 8'd1;
                            end
                        end
`else
                        // First period_end closes the partial period, the second ends the dead time.
                        if (!dir_mismatch) begin
                            state_d = StRun;
                        end else if (period_end) begin
                            if (dead_q) begin
                                dir_d   = ~dir_q;
                                state_d = StRun;
                            end else begin
                                dead_d = 1'b1;
                            end
                        end
`endif
                    end
                end
                default: begin
                    state_d = StIdle;
                    duty_d  = '0;
                end
            endcase
        end
        // Computed from next state so brake/fault/disable silence the output immediately.
        pwm_d = (state_d == StRun) && (counter < duty_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            pwm_q   <= pwm_d;
        end
    end

`ifdef MOTOR_PWM_CTRL_RAMP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end

    assign busy = (state_q == StReverse) || ((state_q == StRun) && (duty_q != pwm_target));
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dead_q <= 1'b0;
        end else begin
            dead_q <= dead_d;
        end
    end

    assign busy = (state_q == StReverse);
`endif

    assign pwm_out       = pwm_q;
    assign enable_out    = (state_q == StRun) || (state_q == StReverse) || (state_q == StBrake);
    assign brake_out     = (state_q == StBrake);
    assign fault_latched = (state_q == StFault);
    assign direction_out = dir_q;
    assign duty_applied  = duty_q;

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Directed bench for motor_pwm_ctrl (CLK_DIV=2, RAMP_PERIODS=1); per-period duty scoreboard.
module tb_motor_pwm_ctrl;

    localparam int Period = 64;
`ifdef MOTOR_PWM_CTRL_RAMP_EN
    localparam bit RampEn = 1'b1;
`else
    localparam bit RampEn = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] pwm_target = '0;
    logic       enable_req = 1'b0;
    logic       brake_req = 1'b0;
    logic       direction_req = 1'b0;
    logic       fault_in = 1'b0;
    logic       fault_clear = 1'b0;
    logic       pwm_out, enable_out, brake_out, direction_out, fault_latched, busy;
    logic [4:0] duty_applied;

    motor_pwm_ctrl #(
        .CLK_DIV     (2),
        .RAMP_PERIODS(1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pwm_target   (pwm_target),
        .enable_req   (enable_req),
        .brake_req    (brake_req),
        .direction_req(direction_req),
        .fault_in     (fault_in),
        .fault_clear  (fault_clear),
        .pwm_out      (pwm_out),
        .enable_out   (enable_out),
        .brake_out    (brake_out),
        .direction_out(direction_out),
        .duty_applied (duty_applied),
        .fault_latched(fault_latched),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int duty;
        int dir;
        int busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   edge_n;
    int   dir_toggles = 0;
    int   dir_glitches = 0;
    logic prev_dir = 1'b0;

    // Bench-side timebase: edge n is a period_end edge when n is a multiple of 64.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) edge_n <= 0;
        else          edge_n <= edge_n + 1;
    end

    always @(negedge clock) begin
        prev_dir <= direction_out;
        if (reset_n && (direction_out !== prev_dir)) begin
            dir_toggles <= dir_toggles + 1;
            if (pwm_out !== 1'b0) dir_glitches <= dir_glitches + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_pe();
        do @(negedge clock); while (edge_n % Period != 0);
    endtask

    task automatic push(input int d, input int dir, input int b);
        exp_q.push_back('{duty: d, dir: dir, busy: b});
    endtask

    task automatic run_periods(input string tag);
        while (exp_q.size() > 0) begin
            exp_t e;
            wait_pe();
            e = exp_q.pop_front();
            check({tag, "_duty"}, duty_applied, e.duty);
            check({tag, "_dir"}, direction_out, e.dir);
            check({tag, "_busy"}, busy, e.busy);
        end
    endtask

    task automatic measure_high(input string tag, input int exp);
        int cnt;
        cnt = 0;
        repeat (Period) begin
            if (pwm_out === 1'b1) cnt++;
            @(negedge clock);
        end
        check(tag, cnt, exp);
    endtask

    initial begin
        int idle_high;

        tick(3);
        check("rst_pwm", pwm_out, 0);
        check("rst_enable", enable_out, 0);
        check("rst_brake", brake_out, 0);
        check("rst_dir", direction_out, 0);
        check("rst_duty", duty_applied, 0);
        check("rst_fault", fault_latched, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;

        idle_high = 0;
        repeat (500) begin
            @(negedge clock);
            if (pwm_out !== 1'b0) idle_high++;
        end
        check("idle_pwm_high", idle_high, 0);
        check("idle_enable", enable_out, 0);

        // Ramp up to 16.
        pwm_target = 5'd16;
        enable_req = 1'b1;
        tick(1);
        check("run_enable", enable_out, 1);
        check("run_busy", busy, RampEn ? 1 : 0);
        for (int k = 1; k <= 16; k++) push(RampEn ? k : 16, 0, (RampEn && k < 16) ? 1 : 0);
        run_periods("ramp_up");
        measure_high("duty16_high", 32);

        // Reversal.
        direction_req = 1'b1;
        if (RampEn) begin
            for (int j = 1; j <= 33; j++)
                push(j <= 16 ? 16 - j : (j == 17 ? 0 : j - 17), j >= 17 ? 1 : 0, j < 33 ? 1 : 0);
        end else begin
            push(0, 0, 1);
            push(0, 1, 0);
            push(16, 1, 0);
        end
        run_periods("reverse");
        check("dir_toggles", dir_toggles, 1);
        check("dir_glitches", dir_glitches, 0);

        // Down to 10, then brake mid high-time.
        pwm_target = 5'd10;
        if (RampEn) for (int j = 1; j <= 6; j++) push(16 - j, 1, (16 - j != 10) ? 1 : 0);
        else        push(10, 1, 0);
        run_periods("to10");
        tick(5);
        check("pre_brake_pwm", pwm_out, 1);
        brake_req = 1'b1;
        tick(1);
        check("brake_out", brake_out, 1);
        check("brake_duty", duty_applied, 0);
        check("brake_pwm", pwm_out, 0);
        check("brake_busy", busy, 0);
        tick(20);
        check("brake_hold", brake_out, 1);
        brake_req = 1'b0;
        tick(1);
        check("brake_release", brake_out, 0);
        for (int k = 1; k <= 10; k++) push(RampEn ? k : 10, 1, (RampEn && k < 10) ? 1 : 0);
        run_periods("unbrake");

        // Fault pulse, ignored clear, then valid clear.
        tick(3);
        fault_in = 1'b1;
        tick(3);
        fault_in = 1'b0;
        check("fault_latch", fault_latched, 1);
        check("fault_enable", enable_out, 0);
        check("fault_pwm", pwm_out, 0);
        check("fault_duty", duty_applied, 0);
        check("fault_brake", brake_out, 0);
        tick(5);
        check("fault_sticky", fault_latched, 1);
        fault_in = 1'b1;
        tick(4);
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        check("clear_ignored", fault_latched, 1);
        tick(1);
        fault_in = 1'b0;
        tick(4);
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        check("clear_fault", fault_latched, 0);
        check("clear_idle_enable", enable_out, 0);
        tick(1);
        check("rerun_enable", enable_out, 1);
        for (int k = 1; k <= 3; k++) push(RampEn ? k : 10, 1, RampEn ? 1 : 0);
        run_periods("post_fault");

        // Full duty, then disable.
        pwm_target = 5'd31;
        if (RampEn) for (int j = 1; j <= 28; j++) push(3 + j, 1, (3 + j != 31) ? 1 : 0);
        else        push(31, 1, 0);
        run_periods("to31");
        measure_high("duty31_high", 62);
        tick(4);
        enable_req = 1'b0;
        tick(1);
        check("disable_duty", duty_applied, 0);
        check("disable_enable", enable_out, 0);
        check("disable_pwm", pwm_out, 0);
        check("disable_busy", busy, 0);

        // Reset asserted mid-ramp.
        pwm_target = 5'd20;
        enable_req = 1'b1;
        tick(1);
        push(RampEn ? 1 : 20, 1, RampEn ? 1 : 0);
        push(RampEn ? 2 : 20, 1, RampEn ? 1 : 0);
        run_periods("pre_reset");
        check("final_dir_toggles", dir_toggles, 1);
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_duty", duty_applied, 0);
        check("areset_dir", direction_out, 0);
        check("areset_enable", enable_out, 0);
        check("areset_pwm", pwm_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
